exec_ctrl: RTL

- Sequencing controller for the 16-bit execute stage (sub/movl/movh/ld/st/jz/jnz/js/jns/halt).
- Sits between decode and execute and decides each cycle whether the decoded instruction issues, stalls or is squashed.
- Tracks registers with outstanding loads in a scoreboard and flushes fetch/decode on a taken branch.
- Drains outstanding loads before entering halt.

---
 rtl/exec_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/exec_ctrl.sv
// Issue/stall/squash sequencer between decode and execute with a load scoreboard.
// issue/stall/flush/redirect are combinational; pending and halted are registered (1 cycle).
// Decode is held by stall on scoreboard hazards, when the load limit is reached, and while draining before halt.
module exec_ctrl #(
    parameter int MAX_LD    = 2,
    parameter int FLUSH_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [3:0]  dec_ra,
    input  logic [3:0]  dec_rb,
    input  logic [3:0]  dec_rt,
    input  logic        dec_use_a,
    input  logic        dec_use_b,
    input  logic        dec_wr,
    input  logic        dec_ld,
    input  logic        dec_halt,
    input  logic        ex_valid,
    input  logic [15:0] ex_pc,
    input  logic [15:0] ex_pc2,
    input  logic        ld_done,
    input  logic [3:0]  ld_rt,
    output logic        issue,
    output logic        stall,
    output logic        flush,
    output logic        redirect,
    output logic [15:0] redirect_pc,
    output logic        halted,
    output logic [15:0] pending
);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALT} state_t;

    localparam logic [2:0] LD_MAX = 3'(MAX_LD);
    localparam logic [1:0] FL_INIT = 2'(FLUSH_CYC - 1);

    state_t      state, state_nxt;
    logic [2:0]  ld_cnt;
    logic [1:0]  flush_cnt, flush_nxt;
    logic [15:0] pc_seq;
    logic        mispredict;
    logic        hazard;
    logic        ld_set, ld_clr;
    logic [15:0] pending_nxt;

    assign pc_seq     = ex_pc + 16'd2;
    assign mispredict = ex_valid && (ex_pc2 != pc_seq);

    assign hazard = dec_valid && ((dec_use_a && pending[dec_ra]) ||
                                  (dec_use_b && pending[dec_rb]) ||
                                  (dec_wr    && pending[dec_rt]) ||
                                  (dec_ld    && ld_cnt == LD_MAX));

    always_comb begin
        issue       = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'd0;
        state_nxt   = state;
        flush_nxt   = flush_cnt;
        case (state)
            RUN, FLUSH, DRAIN: begin
                if (mispredict) begin
                    // An older instruction's redirect overrides stalls and a pending halt.
                    redirect    = 1'b1;
                    redirect_pc = ex_pc2;
                    flush       = 1'b1;
                    state_nxt   = FLUSH;
                    flush_nxt   = FL_INIT;
                end else if (state == FLUSH) begin
                    flush = 1'b1;
                    if (flush_cnt == 2'd0)
                        state_nxt = RUN;
                    else
                        flush_nxt = flush_cnt - 2'd1;
                end else if (state == DRAIN) begin
                    stall = 1'b1;
                    if (ld_cnt == 3'd0)
                        state_nxt = HALT;
                end else if (dec_valid && dec_halt) begin
                    stall     = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    stall = hazard;
                    issue = dec_valid && !hazard;
                end
            end
            default: stall = 1'b1;
        endcase
    end

    assign ld_set = issue && dec_ld;
    // A return for a register not in flight is stale (e.g. issued before reset).
    assign ld_clr = ld_done && pending[ld_rt] && (ld_cnt != 3'd0);

    always_comb begin
        pending_nxt = pending;
        if (ld_clr)
            pending_nxt[ld_rt] = 1'b0;
        if (ld_set)
            pending_nxt[dec_rt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pending   <= 16'd0;
            ld_cnt    <= 3'd0;
            flush_cnt <= 2'd0;
            halted    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            flush_cnt <= flush_nxt;
            halted    <= (state_nxt == HALT);
            case ({ld_set, ld_clr})
                2'b10:   ld_cnt <= ld_cnt + 3'd1;
                2'b01:   ld_cnt <= ld_cnt - 3'd1;
                default: ld_cnt <= ld_cnt;
            endcase
        end
    end

endmodule
